// File: rtl/apb_req_queue.sv
// apb_req_queue: command FIFO and sequencer feeding an APB master.
// Buffers read/write commands and issues them one at a time on
// transfer/PWRITE/address/data, then returns read data on a
// valid/ready response port.
//
// Ports:
//   PCLK, PRESETn       clock, synchronous active-low reset
//   cmd_*               producer command port (valid/ready)
//   transfer, PWRITE,
//   APB_*_ADDRESS,
//   APB_DATA            registered request to the APB master
//   xfer_done,
//   APB_read_data_out   completion pulse and read data from master
//   rsp_*               read response port (valid/ready)
//   count               occupied entries
//   err_stray           sticky: xfer_done seen outside ISSUE
module apb_req_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       PCLK,
    input  logic                       PRESETn,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [ADDR_W-1:0]          cmd_addr,
    input  logic [DATA_W-1:0]          cmd_wdata,
    output logic                       transfer,
    output logic                       PWRITE,
    output logic [ADDR_W-1:0]          APB_write_ADDRESS,
    output logic [ADDR_W-1:0]          APB_read_ADDRESS,
    output logic [DATA_W-1:0]          APB_DATA,
    input  logic                       xfer_done,
    input  logic [DATA_W-1:0]          APB_read_data_out,
    output logic                       rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    input  logic                       rsp_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err_stray
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_e;

    state_e state_q, state_d;

    logic              wr_mem_q   [DEPTH];
    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic              transfer_q, transfer_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              err_q, err_d;

    logic              push;
    logic              pop;
    logic              head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;

    assign cmd_ready  = (count_q != CW'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign head_write = wr_mem_q[rd_ptr_q];
    assign head_addr  = addr_mem_q[rd_ptr_q];
    assign head_wdata = data_mem_q[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        transfer_d  = transfer_q;
        pwrite_d    = pwrite_q;
        waddr_d     = waddr_q;
        raddr_d     = raddr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        err_d       = err_q;
        pop         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (xfer_done) err_d = 1'b1;
                if (count_q != '0) begin
                    state_d    = S_ISSUE;
                    transfer_d = 1'b1;
                    pwrite_d   = head_write;
                    if (head_write) begin
                        waddr_d = head_addr;
                        raddr_d = '0;
                        wdata_d = head_wdata;
                    end else begin
                        waddr_d = '0;
                        raddr_d = head_addr;
                        wdata_d = '0;
                    end
                end
            end
            S_ISSUE: begin
                if (xfer_done) begin
                    pop        = 1'b1;
                    transfer_d = 1'b0;
                    if (pwrite_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = APB_read_data_out;
                    end
                end
            end
            S_RESP: begin
                if (xfer_done) err_d = 1'b1;
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: entries are only read when count says so.
    always_ff @(posedge PCLK) begin
        if (push) begin
            wr_mem_q[wr_ptr_q]   <= cmd_write;
            addr_mem_q[wr_ptr_q] <= cmd_addr;
            data_mem_q[wr_ptr_q] <= cmd_wdata;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            transfer_q  <= 1'b0;
            pwrite_q    <= 1'b0;
            waddr_q     <= '0;
            raddr_q     <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            transfer_q  <= transfer_d;
            pwrite_q    <= pwrite_d;
            waddr_q     <= waddr_d;
            raddr_q     <= raddr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_q       <= err_d;
        end
    end

    assign transfer          = transfer_q;
    assign PWRITE            = pwrite_q;
    assign APB_write_ADDRESS = waddr_q;
    assign APB_read_ADDRESS  = raddr_q;
    assign APB_DATA          = wdata_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_rdata         = rsp_rdata_q;
    assign count             = count_q;
    assign err_stray         = err_q;

endmodule

// File: tb/tb_apb_req_queue.sv
// tb_apb_req_queue: directed self-checking bench for apb_req_queue.
// Inputs change 1 time unit after the rising edge; outputs sampled there.
module tb_apb_req_queue;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        transfer;
    logic        PWRITE;
    logic [31:0] APB_write_ADDRESS;
    logic [31:0] APB_read_ADDRESS;
    logic [31:0] APB_DATA;
    logic        xfer_done;
    logic [31:0] APB_read_data_out;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_ready;
    logic [3:0]  count;
    logic        err_stray;

    int n_checks = 0;
    int n_errors = 0;

    apb_req_queue #(.DEPTH(8), .ADDR_W(32), .DATA_W(32)) dut (
        .PCLK              (PCLK),
        .PRESETn           (PRESETn),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_write         (cmd_write),
        .cmd_addr          (cmd_addr),
        .cmd_wdata         (cmd_wdata),
        .transfer          (transfer),
        .PWRITE            (PWRITE),
        .APB_write_ADDRESS (APB_write_ADDRESS),
        .APB_read_ADDRESS  (APB_read_ADDRESS),
        .APB_DATA          (APB_DATA),
        .xfer_done         (xfer_done),
        .APB_read_data_out (APB_read_data_out),
        .rsp_valid         (rsp_valid),
        .rsp_rdata         (rsp_rdata),
        .rsp_ready         (rsp_ready),
        .count             (count),
        .err_stray         (err_stray)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic push_cmd(input logic w, input logic [31:0] a,
                            input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Complete n writes, expecting addresses base..base+n-1 in order.
    task automatic drain(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            int waits = 0;
            while (!transfer && waits < 5) begin
                tick();
                waits++;
            end
            chk("drain_transfer", 64'(transfer), 64'd1);
            chk("drain_addr", 64'(APB_write_ADDRESS), 64'(base + i));
            chk("drain_data", 64'(APB_DATA), 64'(32'h100 + base + i));
            xfer_done = 1'b1;
            tick();
            xfer_done = 1'b0;
            chk("drain_gap", 64'(transfer), 64'd0);
        end
    endtask

    initial begin
        PRESETn           = 1'b0;
        cmd_valid         = 1'b0;
        cmd_write         = 1'b0;
        cmd_addr          = '0;
        cmd_wdata         = '0;
        xfer_done         = 1'b0;
        APB_read_data_out = '0;
        rsp_ready         = 1'b0;
        tick();
        tick();
        PRESETn = 1'b1;

        chk("rst_transfer", 64'(transfer), 64'd0);
        chk("rst_pwrite", 64'(PWRITE), 64'd0);
        chk("rst_waddr", 64'(APB_write_ADDRESS), 64'd0);
        chk("rst_raddr", 64'(APB_read_ADDRESS), 64'd0);
        chk("rst_data", 64'(APB_DATA), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_err", 64'(err_stray), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // single write, latency and completion
        push_cmd(1'b1, 32'd5, 32'hDEADBEEF);
        chk("w1_count", 64'(count), 64'd1);
        chk("w1_not_yet", 64'(transfer), 64'd0);
        tick();
        chk("w1_transfer", 64'(transfer), 64'd1);
        chk("w1_pwrite", 64'(PWRITE), 64'd1);
        chk("w1_waddr", 64'(APB_write_ADDRESS), 64'd5);
        chk("w1_raddr", 64'(APB_read_ADDRESS), 64'd0);
        chk("w1_data", 64'(APB_DATA), 64'hDEADBEEF);
        tick();
        chk("w1_hold", 64'(transfer), 64'd1);
        chk("w1_hold_addr", 64'(APB_write_ADDRESS), 64'd5);
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        chk("w1_done", 64'(transfer), 64'd0);
        chk("w1_count0", 64'(count), 64'd0);
        chk("w1_no_err", 64'(err_stray), 64'd0);

        // write then read back
        push_cmd(1'b1, 32'd8, 32'h12345678);
        push_cmd(1'b0, 32'd8, 32'h0);
        chk("wr_transfer", 64'(transfer), 64'd1);
        chk("wr_pwrite", 64'(PWRITE), 64'd1);
        chk("wr_waddr", 64'(APB_write_ADDRESS), 64'd8);
        chk("wr_count", 64'(count), 64'd2);
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        chk("wr_gap", 64'(transfer), 64'd0);
        chk("wr_count1", 64'(count), 64'd1);
        tick();
        chk("rd_transfer", 64'(transfer), 64'd1);
        chk("rd_pwrite", 64'(PWRITE), 64'd0);
        chk("rd_raddr", 64'(APB_read_ADDRESS), 64'd8);
        chk("rd_waddr", 64'(APB_write_ADDRESS), 64'd0);
        chk("rd_data", 64'(APB_DATA), 64'd0);
        xfer_done         = 1'b1;
        APB_read_data_out = 32'h12345678;
        tick();
        xfer_done         = 1'b0;
        APB_read_data_out = '0;
        chk("rd_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rd_rsp_rdata", 64'(rsp_rdata), 64'h12345678);
        chk("rd_transfer0", 64'(transfer), 64'd0);
        chk("rd_count0", 64'(count), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rsp_hold_valid", 64'(rsp_valid), 64'd1);
            chk("rsp_hold_data", 64'(rsp_rdata), 64'h12345678);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_clear", 64'(rsp_valid), 64'd0);
        tick();
        chk("rsp_no_issue", 64'(transfer), 64'd0);
        chk("rsp_no_err", 64'(err_stray), 64'd0);

        // fill to full
        for (int i = 0; i < 8; i++) begin
            push_cmd(1'b1, 32'(i), 32'h100 + 32'(i));
        end
        chk("full_count", 64'(count), 64'd8);
        chk("full_ready", 64'(cmd_ready), 64'd0);
        chk("full_head", 64'(APB_write_ADDRESS), 64'd0);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'd99;
        cmd_wdata = 32'h99;
        tick();
        chk("full_refuse", 64'(count), 64'd8);
        // pop while full with a push pending: push must be refused
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        cmd_valid = 1'b0;
        chk("fullpop_count", 64'(count), 64'd7);
        chk("fullpop_ready", 64'(cmd_ready), 64'd1);
        drain(1, 7);
        chk("drain_count", 64'(count), 64'd0);

        // wrap pointers with a second full lap
        for (int i = 8; i < 16; i++) begin
            push_cmd(1'b1, 32'(i), 32'h100 + 32'(i));
        end
        chk("wrap_count", 64'(count), 64'd8);
        drain(8, 8);
        chk("wrap_count0", 64'(count), 64'd0);

        // stray completion in IDLE
        tick();
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        chk("stray_err", 64'(err_stray), 64'd1);
        chk("stray_count", 64'(count), 64'd0);
        chk("stray_transfer", 64'(transfer), 64'd0);
        chk("stray_rsp", 64'(rsp_valid), 64'd0);
        tick();
        chk("stray_sticky", 64'(err_stray), 64'd1);

        // reset mid-transfer
        push_cmd(1'b1, 32'h20, 32'hA0);
        push_cmd(1'b1, 32'h21, 32'hA1);
        push_cmd(1'b1, 32'h22, 32'hA2);
        chk("mid_transfer", 64'(transfer), 64'd1);
        PRESETn = 1'b0;
        tick();
        chk("mr_transfer", 64'(transfer), 64'd0);
        chk("mr_count", 64'(count), 64'd0);
        chk("mr_pwrite", 64'(PWRITE), 64'd0);
        chk("mr_waddr", 64'(APB_write_ADDRESS), 64'd0);
        chk("mr_data", 64'(APB_DATA), 64'd0);
        chk("mr_err", 64'(err_stray), 64'd0);
        chk("mr_ready", 64'(cmd_ready), 64'd1);
        PRESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_idle", 64'(transfer), 64'd0);
        end
        chk("post_rst_count", 64'(count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
